// File: rtl/write_forward_buffer.sv
// Per-table write-history buffer: corrects stale memory read words with the
// newest matching in-flight write (current write, then history slot 0..DEPTH-1).
module wfb_table #(
    parameter int DW              = 4,
    parameter int KW              = 2,
    parameter int DEPTH           = 2,
    parameter int AW              = 2,
    parameter int SIG_AW          = 2,
    parameter int INCLUDE_CURRENT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_adr_i,
    input  logic [KW-1:0] wr_key_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          wr_valid_i,
    input  logic          mem_ret_i,
    input  logic [AW-1:0] mem_adr_i,
    input  logic [KW-1:0] mem_key_i,
    input  logic [DW-1:0] mem_data_i,
    input  logic          mem_valid_i,
    output logic          corr_ret_o,
    output logic [KW-1:0] corr_key_o,
    output logic [DW-1:0] corr_data_o,
    output logic          corr_valid_o,
    output logic          corr_hit_o
);
    typedef struct packed {
        logic          used;
        logic [AW-1:0] adr;
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        logic          valid;
    } entry_t;

    typedef struct packed {
        logic          ret;
        logic [KW-1:0] key;
        logic [DW-1:0] data;
        logic          valid;
        logic          hit;
    } corr_t;

    // Only the table's significant address bits take part in the compare.
    localparam logic [AW-1:0] ADR_MASK = AW'((64'd1 << SIG_AW) - 64'd1);

    entry_t [DEPTH-1:0] hist_q, hist_d;
    entry_t             wr_ent;
    corr_t              corr_q, corr_d;
    logic               cur_match;

    assign wr_ent    = '{used: wr_en_i, adr: wr_adr_i, key: wr_key_i, data: wr_data_i, valid: wr_valid_i};
    assign cur_match = wr_en_i && (((wr_adr_i ^ mem_adr_i) & ADR_MASK) == '0);

    // Walk oldest to newest so the last (youngest) match overrides older ones.
    always_comb begin
        corr_d = '{ret: mem_ret_i, key: mem_key_i, data: mem_data_i, valid: mem_valid_i, hit: 1'b0};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hist_q[i].used && (((hist_q[i].adr ^ mem_adr_i) & ADR_MASK) == '0)) begin
                corr_d.key   = hist_q[i].key;
                corr_d.data  = hist_q[i].data;
                corr_d.valid = hist_q[i].valid;
                corr_d.hit   = 1'b1;
            end
        end
        if ((INCLUDE_CURRENT != 0) && cur_match) begin
            corr_d.key   = wr_key_i;
            corr_d.data  = wr_data_i;
            corr_d.valid = wr_valid_i;
            corr_d.hit   = 1'b1;
        end
    end

    always_comb begin
        hist_d = '0;
        if (!flush_i) begin
            hist_d[0] = wr_ent;
            for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            corr_q <= '0;
        end else if (clk_en) begin
            hist_q <= hist_d;
            corr_q <= corr_d;
        end
    end

    assign corr_ret_o   = corr_q.ret;
    assign corr_key_o   = corr_q.key;
    assign corr_data_o  = corr_q.data;
    assign corr_valid_o = corr_q.valid;
    assign corr_hit_o   = corr_q.hit;
endmodule

module write_forward_buffer #(
    parameter int DATA_WIDTH         = 4,
    parameter int KEY_WIDTH          = 2,
    parameter int NUMBER_OF_TABLES   = 3,
    parameter int FORWARD_DEPTH      = 2,
    parameter int MAX_HASH_ADR_WIDTH = 2,
    parameter int HASH_TABLE_ADR_WIDTH [NUMBER_OF_TABLES-1:0] = '{2, 2, 2},
    parameter int INCLUDE_CURRENT    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic                          flush_i,
    input  logic                          wr_en_i      [NUMBER_OF_TABLES-1:0],
    input  logic [MAX_HASH_ADR_WIDTH-1:0] wr_adr_i     [NUMBER_OF_TABLES-1:0],
    input  logic [KEY_WIDTH-1:0]          wr_key_i     [NUMBER_OF_TABLES-1:0],
    input  logic [DATA_WIDTH-1:0]         wr_data_i    [NUMBER_OF_TABLES-1:0],
    input  logic                          wr_valid_i   [NUMBER_OF_TABLES-1:0],
    input  logic                          mem_ret_i    [NUMBER_OF_TABLES-1:0],
    input  logic [MAX_HASH_ADR_WIDTH-1:0] mem_adr_i    [NUMBER_OF_TABLES-1:0],
    input  logic [KEY_WIDTH-1:0]          mem_key_i    [NUMBER_OF_TABLES-1:0],
    input  logic [DATA_WIDTH-1:0]         mem_data_i   [NUMBER_OF_TABLES-1:0],
    input  logic                          mem_valid_i  [NUMBER_OF_TABLES-1:0],
    output logic                          corr_ret_o   [NUMBER_OF_TABLES-1:0],
    output logic [KEY_WIDTH-1:0]          corr_key_o   [NUMBER_OF_TABLES-1:0],
    output logic [DATA_WIDTH-1:0]         corr_data_o  [NUMBER_OF_TABLES-1:0],
    output logic                          corr_valid_o [NUMBER_OF_TABLES-1:0],
    output logic                          corr_hit_o   [NUMBER_OF_TABLES-1:0]
);
    for (genvar t = 0; t < NUMBER_OF_TABLES; t++) begin : g_tbl
        wfb_table #(
            .DW(DATA_WIDTH), .KW(KEY_WIDTH), .DEPTH(FORWARD_DEPTH), .AW(MAX_HASH_ADR_WIDTH),
            .SIG_AW(HASH_TABLE_ADR_WIDTH[t]), .INCLUDE_CURRENT(INCLUDE_CURRENT)
        ) u_tbl (
            .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush_i),
            .wr_en_i(wr_en_i[t]), .wr_adr_i(wr_adr_i[t]), .wr_key_i(wr_key_i[t]),
            .wr_data_i(wr_data_i[t]), .wr_valid_i(wr_valid_i[t]),
            .mem_ret_i(mem_ret_i[t]), .mem_adr_i(mem_adr_i[t]), .mem_key_i(mem_key_i[t]),
            .mem_data_i(mem_data_i[t]), .mem_valid_i(mem_valid_i[t]),
            .corr_ret_o(corr_ret_o[t]), .corr_key_o(corr_key_o[t]), .corr_data_o(corr_data_o[t]),
            .corr_valid_o(corr_valid_o[t]), .corr_hit_o(corr_hit_o[t])
        );
    end
endmodule

// File: tb/tb_write_forward_buffer.sv
// Scoreboard bench: two DUTs (current-write forwarding on/off) share one directed stimulus.
module tb_write_forward_buffer;
    logic       clk = 1'b0;
    logic       reset, clk_en, flush;
    logic       wr_en [2:0], wr_valid [2:0], mem_ret [2:0], mem_valid [2:0];
    logic [1:0] wr_adr [2:0], wr_key [2:0], mem_adr [2:0], mem_key [2:0];
    logic [3:0] wr_data [2:0], mem_data [2:0];

    logic       a_ret [2:0], a_valid [2:0], a_hit [2:0], b_ret [2:0], b_valid [2:0], b_hit [2:0];
    logic [1:0] a_key [2:0], b_key [2:0];
    logic [3:0] a_data [2:0], b_data [2:0];

    typedef struct packed {
        logic [2:0]       ret;
        logic [2:0][1:0]  key;
        logic [2:0][3:0]  data;
        logic [2:0]       valid;
        logic [2:0]       hit;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb, oa, ob;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    // A: current write forwards, table 0 uses only address bit 0.
    write_forward_buffer #(.HASH_TABLE_ADR_WIDTH('{2, 2, 1}), .INCLUDE_CURRENT(1)) dut_a (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush),
        .wr_en_i(wr_en), .wr_adr_i(wr_adr), .wr_key_i(wr_key), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
        .mem_ret_i(mem_ret), .mem_adr_i(mem_adr), .mem_key_i(mem_key), .mem_data_i(mem_data),
        .mem_valid_i(mem_valid),
        .corr_ret_o(a_ret), .corr_key_o(a_key), .corr_data_o(a_data), .corr_valid_o(a_valid),
        .corr_hit_o(a_hit));

    write_forward_buffer #(.HASH_TABLE_ADR_WIDTH('{2, 2, 2}), .INCLUDE_CURRENT(0)) dut_b (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush_i(flush),
        .wr_en_i(wr_en), .wr_adr_i(wr_adr), .wr_key_i(wr_key), .wr_data_i(wr_data), .wr_valid_i(wr_valid),
        .mem_ret_i(mem_ret), .mem_adr_i(mem_adr), .mem_key_i(mem_key), .mem_data_i(mem_data),
        .mem_valid_i(mem_valid),
        .corr_ret_o(b_ret), .corr_key_o(b_key), .corr_data_o(b_data), .corr_valid_o(b_valid),
        .corr_hit_o(b_hit));

    always_comb begin
        oa = '0;
        ob = '0;
        for (int t = 0; t < 3; t++) begin
            oa.ret[t] = a_ret[t]; oa.key[t] = a_key[t]; oa.data[t] = a_data[t];
            oa.valid[t] = a_valid[t]; oa.hit[t] = a_hit[t];
            ob.ret[t] = b_ret[t]; ob.key[t] = b_key[t]; ob.data[t] = b_data[t];
            ob.valid[t] = b_valid[t]; ob.hit[t] = b_hit[t];
        end
    end

    task automatic cmp(input string nm, input exp_t got, input exp_t e);
        checks++;
        if (got.ret !== e.ret) begin
            errors++;
            $display("FAIL %s ret got %b exp %b", nm, got.ret, e.ret);
        end
        for (int t = 0; t < 3; t++) begin
            if (e.ret[t]) begin
                checks++;
                if ({got.key[t], got.data[t], got.valid[t], got.hit[t]} !==
                    {e.key[t], e.data[t], e.valid[t], e.hit[t]}) begin
                    errors++;
                    $display("FAIL %s t%0d got key%0d data%0d valid%0d hit%0d exp key%0d data%0d valid%0d hit%0d",
                             nm, t, got.key[t], got.data[t], got.valid[t], got.hit[t],
                             e.key[t], e.data[t], e.valid[t], e.hit[t]);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (|oa.ret) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL A unexpected ret got %b exp none", oa.ret);
            end else cmp("A", oa, qa.pop_front());
        end
        if (|ob.ret) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL B unexpected ret got %b exp none", ob.ret);
            end else cmp("B", ob, qb.pop_front());
        end
    end

    task automatic clr();
        for (int t = 0; t < 3; t++) begin
            wr_en[t] = 0; wr_adr[t] = 0; wr_key[t] = 0; wr_data[t] = 0; wr_valid[t] = 0;
            mem_ret[t] = 0; mem_adr[t] = 0; mem_key[t] = 0; mem_data[t] = 0; mem_valid[t] = 0;
        end
        flush = 0; clk_en = 1; ea = '0; eb = '0;
    endtask

    task automatic wr(input int t, input logic [1:0] a, input logic [1:0] k, input logic [3:0] d, input logic v);
        wr_en[t] = 1; wr_adr[t] = a; wr_key[t] = k; wr_data[t] = d; wr_valid[t] = v;
    endtask

    // Return a memory word; default expectation is pass-through without hit.
    task automatic ret(input int t, input logic [1:0] a, input logic [1:0] k, input logic [3:0] d, input logic v);
        mem_ret[t] = 1; mem_adr[t] = a; mem_key[t] = k; mem_data[t] = d; mem_valid[t] = v;
        ea.ret[t] = 1; ea.key[t] = k; ea.data[t] = d; ea.valid[t] = v; ea.hit[t] = 0;
        eb.ret[t] = 1; eb.key[t] = k; eb.data[t] = d; eb.valid[t] = v; eb.hit[t] = 0;
    endtask

    // Expect a forwarded word: which[0] -> DUT A, which[1] -> DUT B.
    task automatic fwd(input logic [1:0] which, input int t, input logic [1:0] k, input logic [3:0] d, input logic v);
        if (which[0]) begin ea.key[t] = k; ea.data[t] = d; ea.valid[t] = v; ea.hit[t] = 1; end
        if (which[1]) begin eb.key[t] = k; eb.data[t] = d; eb.valid[t] = v; eb.hit[t] = 1; end
    endtask

    task automatic tick();
        if (|ea.ret) qa.push_back(ea);
        if (|eb.ret) qb.push_back(eb);
        @(posedge clk);
        @(negedge clk);
        clr();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clr();
        // Reset held over two edges with writes active everywhere.
        reset = 1;
        for (int t = 0; t < 3; t++) wr(t, 2'd1, 2'd1, 4'd5, 1'b1);
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if (oa !== '0) begin errors++; $display("FAIL reset A got %h exp 0", oa); end
        checks++;
        if (ob !== '0) begin errors++; $display("FAIL reset B got %h exp 0", ob); end
        clr();
        reset = 0;
        for (int t = 0; t < 3; t++) ret(t, 2'd1, 2'd2, 4'd9, 1'b1);
        tick();
        idle(1);

        // Basic forward from slot 0.
        wr(0, 2'd1, 2'd3, 4'd3, 1'b1); tick();
        ret(0, 2'd1, 2'd0, 4'd0, 1'b0); ret(1, 2'd1, 2'd1, 4'd1, 1'b1); ret(2, 2'd1, 2'd2, 4'd2, 1'b0);
        fwd(2'b11, 0, 2'd3, 4'd3, 1'b1);
        tick();
        idle(2);

        // Ageing: hit from the oldest slot, then aged out.
        wr(0, 2'd1, 2'd3, 4'd3, 1'b1); tick();
        tick();
        ret(0, 2'd1, 2'd0, 4'd0, 1'b0); fwd(2'b11, 0, 2'd3, 4'd3, 1'b1); tick();
        ret(0, 2'd1, 2'd0, 4'd0, 1'b0); tick();
        idle(2);

        // Disabled cycles do not age history and ignore writes and flush.
        wr(0, 2'd1, 2'd3, 4'd3, 1'b1); tick();
        clk_en = 0; flush = 1; wr(0, 2'd1, 2'd1, 4'd7, 1'b1); tick();
        clk_en = 0; wr(0, 2'd1, 2'd1, 4'd7, 1'b1); tick();
        ret(0, 2'd1, 2'd0, 4'd0, 1'b0); fwd(2'b11, 0, 2'd3, 4'd3, 1'b1); tick();
        idle(2);

        // Newest wins; delete in the return cycle forwards only with current-write forwarding.
        wr(0, 2'd2, 2'd1, 4'd1, 1'b1); tick();
        wr(0, 2'd2, 2'd1, 4'd2, 1'b1); tick();
        wr(0, 2'd2, 2'd1, 4'd0, 1'b0);
        ret(0, 2'd2, 2'd2, 4'd15, 1'b1); ret(1, 2'd2, 2'd3, 4'd4, 1'b1);
        fwd(2'b01, 0, 2'd1, 4'd0, 1'b0);
        fwd(2'b10, 0, 2'd1, 4'd2, 1'b1);
        tick();
        idle(2);

        // Address masking: table 0 of A ignores bit 1.
        wr(0, 2'd3, 2'd1, 4'd6, 1'b1); wr(1, 2'd3, 2'd1, 4'd6, 1'b1); tick();
        ret(0, 2'd1, 2'd0, 4'd0, 1'b1); ret(1, 2'd1, 2'd0, 4'd0, 1'b1);
        fwd(2'b01, 0, 2'd1, 4'd6, 1'b1);
        tick();
        idle(2);

        // Flush: correction in the flush cycle uses old history; afterwards empty.
        wr(0, 2'd0, 2'd2, 4'd8, 1'b1); tick();
        flush = 1; wr(1, 2'd0, 2'd1, 4'd3, 1'b1);
        ret(0, 2'd0, 2'd0, 4'd1, 1'b0); fwd(2'b11, 0, 2'd2, 4'd8, 1'b1);
        tick();
        ret(0, 2'd0, 2'd1, 4'd2, 1'b1); ret(1, 2'd0, 2'd2, 4'd4, 1'b0);
        tick();
        idle(3);

        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d pending exp 0/0", qa.size(), qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/write_forward_buffer.md
# write_forward_buffer

Per-table write-history buffer for the cuckoo hash pipeline. It records the last FORWARD_DEPTH writes issued to each hash-table memory. Stale words returned by a memory read are corrected with the newest matching in-flight write, so the pipeline never acts on data that a younger write has already replaced. It generalises forwarding to arbitrary depth, table count and per-table address width, and adds delete (valid=0) writes, a flush and hit reporting.

## Interface

- DATA_WIDTH, 4, data field width
- KEY_WIDTH, 2, key field width
- NUMBER_OF_TABLES, 3, number of hash tables (≥1)
- FORWARD_DEPTH, 2, history entries per table (≥1)
- MAX_HASH_ADR_WIDTH, 2, width of all address ports
- HASH_TABLE_ADR_WIDTH, {2,2,2}, integer array [NUMBER_OF_TABLES-1:0]: significant address bits per table; higher bits ignored in compares
- INCLUDE_CURRENT, 1, 1: a write in the same cycle as a memory return also forwards
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clk_en  in  1  global enable; when 0 all state and outputs hold
- flush_i  in  1  synchronous clear of all history entries
- wr_en_i  in  1 ×T  write issued to table t this cycle
- wr_adr_i  in  MAX_HASH_ADR_WIDTH ×T  write address
- wr_key_i  in  KEY_WIDTH ×T  written key
- wr_data_i  in  DATA_WIDTH ×T  written data
- wr_valid_i  in  1 ×T  written valid bit (0 = delete)
- mem_ret_i  in  1 ×T  memory read word present this cycle
- mem_adr_i  in  MAX_HASH_ADR_WIDTH ×T  address of returned word
- mem_key_i / mem_data_i / mem_valid_i  in  KEY_WIDTH / DATA_WIDTH / 1 ×T  word as read from memory
- corr_ret_o  out  1 ×T  corrected word valid
- corr_key_o / corr_data_o / corr_valid_o  out  KEY_WIDTH / DATA_WIDTH / 1 ×T  corrected word
- corr_hit_o  out  1 ×T  1 = word was replaced by a forwarded write

(×T = unpacked array [NUMBER_OF_TABLES-1:0].)

## Operation

- Each table has a shift register of FORWARD_DEPTH entries {used, adr, key, data, valid}. Slot 0 is the newest.
- On each clk_en cycle, every table shifts by one. Slot 0 loads {wr_en_i, wr_adr_i, wr_key_i, wr_data_i, wr_valid_i}.
  - With wr_en_i=0, a bubble (used=0) is pushed, so entry age is always measured in enabled cycles.
  - The oldest entry is discarded.
- Compare: an entry matches when used=1 and adr[HASH_TABLE_ADR_WIDTH[t]-1:0] equals mem_adr_i on the same bits.
- Priority, newest first:
  1. The current write, if INCLUDE_CURRENT=1, wr_en_i=1 and the address matches.
  2. Slot 0.
  3. And so on up to slot FORWARD_DEPTH-1.
- With a match, the output is the matched key/data/valid and corr_hit_o=1. With no match, the output is the mem_* word unchanged and corr_hit_o=0.
- A delete (valid=0) forwards like any write. corr_valid_o=0 and key/data are passed as written.
- Tables are fully independent. A write to table i never affects table j.
- flush_i=1 with clk_en=1: all entries become used=0 and the current write is not recorded. The current cycle's correction still uses the pre-flush history.

## Timing

- Latency 1: mem_* in cycle n gives corr_* registered at the edge ending cycle n. corr_ret_o = registered mem_ret_i.
- The compare uses the history as it stands before this edge's shift.
  - With INCLUDE_CURRENT=1, writes issued in cycles n-FORWARD_DEPTH..n forward to a return in cycle n.
  - With INCLUDE_CURRENT=0, the window is n-FORWARD_DEPTH..n-1.
- clk_en=0 has absolute priority over flush_i and writes: nothing shifts and outputs hold.
- Reset values: all history used=0; corr_ret_o=0, corr_key_o=0, corr_data_o=0, corr_valid_o=0, corr_hit_o=0. Reset asserted mid-stream discards all history immediately.
- Outputs with mem_ret_i=0: corr_ret_o=0, and the other outputs still register the corrected value of the current inputs (don't-care to consumers).
- Two history entries with the same address: the newest always wins.

## Test plan

- Reset: hold reset over 2 edges with writes active -> all corr_* = 0 and no hits on the first return after release.
- Basic forward (T=3, depth 2, INCLUDE_CURRENT=1): write table0 adr1 key3 data3 valid1 in cycle 0; return table0 adr1 mem key0 data0 valid0 in cycle 1 -> corr key3 data3 valid1 hit1 in table0; tables 1 and 2 hit0.
- Ageing: the same write, with the return in cycle 3 (older than depth) -> mem word passed, hit0. Repeat with clk_en=0 for cycles 1–2 -> still hit1, because the age counts only enabled cycles.
- Newest-wins and delete: adr2 writes data1 (cycle 0), data2 (cycle 1), then delete valid0 (cycle 2, same cycle as the return) -> corr valid0 hit1 with INCLUDE_CURRENT=1. With INCLUDE_CURRENT=0, the same stimulus gives data2 valid1.
- Address masking: HASH_TABLE_ADR_WIDTH={2,2,1}; table0 write adr3 and return adr1 -> hit1 (bit 1 ignored); table1 with the same stimulus -> hit0.
- Flush: write adr0 in cycle 0, flush_i in cycle 1 with a return adr0 -> hit1; return adr0 in cycle 2 -> hit0.
